// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF line synchronizer, 16x tick-driven
// start/data/stop FSM, registered done / framing-error pulses.
//
// Handshake: rx_done_tick is a 1-clk valid strobe with no ready; dout is
// stable from the cycle rx_done_tick is high until the next good frame.
// frame_err is a 1-clk strobe that leaves dout untouched.
module uart_rx_os #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_tick,
   input  logic            rx_in,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            busy,
   output logic [1:0]      state_dbg
);

   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 8) ? 4 : 3;

   localparam logic [SW-1:0] S_MID  = SW'(7);
   localparam logic [SW-1:0] S_END  = SW'(15);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic            sync1_q, rx_s_q, rx_prev_q;
   logic [1:0]      state_q, state_d;
   logic [SW-1:0]   s_cnt_q, s_cnt_d;
   logic [NW-1:0]   n_cnt_q, n_cnt_d;
   logic [DBIT-1:0] shift_q, shift_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            stop_ok_q, stop_ok_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            stop_good;

   // Synchronize the raw line and keep one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx_in;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // Receive FSM: find start edge, confirm mid start bit, sample bit centres
   always_comb begin
      state_d   = state_q;
      s_cnt_d   = s_cnt_q;
      n_cnt_d   = n_cnt_q;
      shift_d   = shift_q;
      dout_d    = dout_q;
      stop_ok_d = stop_ok_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      // With a single stop bit the check and the exit share one tick
      stop_good = (s_cnt_q == S_END) ? rx_s_q : stop_ok_q;
      case (state_q)
         IDLE: begin
            // Needs a real high->low transition; a stuck-low line never re-arms
            if (rx_prev_q && !rx_s_q) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_cnt_q == S_MID) begin
                  if (!rx_s_q) begin
                     state_d = DATA;
                     s_cnt_d = '0;
                     n_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_cnt_q == S_END) begin
                  shift_d = {rx_s_q, shift_q[DBIT-1:1]};
                  s_cnt_d = '0;
                  if (n_cnt_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_cnt_d = n_cnt_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_cnt_q == S_STOP) begin
                  state_d = IDLE;
                  if (stop_good) begin
                     dout_d = shift_q;
                     done_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
                  if (s_cnt_q == S_END) begin
                     stop_ok_d = rx_s_q;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters, data and registered output pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         s_cnt_q   <= '0;
         n_cnt_q   <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         stop_ok_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_cnt_q   <= s_cnt_d;
         n_cnt_q   <= n_cnt_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         stop_ok_q <= stop_ok_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = err_q;
   assign busy         = (state_q != IDLE);
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven bit by bit on rx_in,
// the expected {frame_err, dout} for each frame is queued when the frame is
// sent, and a monitor pops and compares on every done/error pulse.
module tb_uart_rx_os;

   localparam int TICK_DIV = 4;             // s_tick every 4 clk
   localparam int BIT      = 16 * TICK_DIV; // nominal bit period in clk

   logic       clk;
   logic       rst;
   logic       s_tick;
   logic       rx_in;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
   logic       busy;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];      // {frame_err, expected dout}
   logic [7:0] last_good = 8'h00;
   logic       prev_pulse = 1'b0;

   uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_tick       (s_tick),
      .rx_in        (rx_in),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .busy         (busy),
      .state_dbg    (state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running oversample tick
   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame; checks busy in the middle of the start bit
   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bclk);
      if (stop_bit) begin
         exp_q.push_back({1'b0, data});
         last_good = data;
      end else begin
         exp_q.push_back({1'b1, last_good});
      end
      rx_in = 1'b0;
      idle_clks(bclk / 2);
      check("busy_in_start", {31'd0, busy}, 32'd1);
      idle_clks(bclk - bclk / 2);
      for (int i = 0; i < 8; i++) begin
         rx_in = data[i];
         idle_clks(bclk);
      end
      rx_in = stop_bit;
      idle_clks(bclk);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rx_done_tick || frame_err) begin
         logic [8:0] exp;
         check("no_double_pulse", {31'd0, prev_pulse}, 32'd0);
         check("done_err_exclusive", {31'd0, rx_done_tick & frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got done=%0b err=%0b dout=0x%0h expected no pulse at %0t",
                     rx_done_tick, frame_err, dout, $time);
         end else begin
            exp = exp_q.pop_front();
            check("frame_result", {23'd0, frame_err, dout}, {23'd0, exp});
         end
      end
      prev_pulse = rx_done_tick | frame_err;
   end

   initial begin
      rst   = 1'b0;
      rx_in = 1'b1;
      idle_clks(5);
      check("reset_dout", {24'd0, dout}, 32'd0);
      check("reset_done", {31'd0, rx_done_tick}, 32'd0);
      check("reset_err", {31'd0, frame_err}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      idle_clks(3 * BIT);

      // 1: single good frame
      send_frame(8'hA5, 1'b1, BIT);
      idle_clks(2 * BIT);
      check("dout_after_a5", {24'd0, dout}, 32'h0000_00A5);

      // 2: back-to-back frames, no idle gap
      send_frame(8'h5A, 1'b1, BIT);
      send_frame(8'h3C, 1'b1, BIT);
      idle_clks(2 * BIT);
      check("dout_after_3c", {24'd0, dout}, 32'h0000_003C);

      // 3: stop bit low, then line held low for two frames
      send_frame(8'h00, 1'b0, BIT);
      idle_clks(20 * BIT);
      check("busy_line_low", {31'd0, busy}, 32'd0);
      check("dout_kept_on_err", {24'd0, dout}, 32'h0000_003C);
      rx_in = 1'b1;
      idle_clks(3 * BIT);

      // 4: short glitch on idle line
      rx_in = 1'b0;
      idle_clks(8);
      rx_in = 1'b1;
      idle_clks(4);
      check("busy_glitch", {31'd0, busy}, 32'd1);
      idle_clks(BIT);
      check("idle_after_glitch", {31'd0, busy}, 32'd0);
      idle_clks(2 * BIT);

      // 5: reset during bit 4 of 0xFF, then a fresh 0x81
      rx_in = 1'b0;
      idle_clks(BIT);
      rx_in = 1'b1;
      idle_clks(4 * BIT + BIT / 2);
      check("busy_before_abort", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_dout", {24'd0, dout}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, rx_done_tick}, 32'd0);
      idle_clks(5);
      rst = 1'b1;
      last_good = 8'h00;
      idle_clks(6 * BIT);
      check("idle_after_abort", {31'd0, busy}, 32'd0);
      send_frame(8'h81, 1'b1, BIT);
      idle_clks(2 * BIT);
      check("dout_after_81", {24'd0, dout}, 32'h0000_0081);

      // 6: bit period -3% and +3%
      send_frame(8'hC3, 1'b1, BIT - 2);
      idle_clks(2 * BIT);
      send_frame(8'hC3, 1'b1, BIT + 2);
      idle_clks(3 * BIT);
      check("dout_after_c3", {24'd0, dout}, 32'h0000_00C3);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
